// File: rtl/hazard_flush_unit.sv
// Hazard/flush control for the KGP-RISC 5-stage pipeline.
// Load-use holds, branch flush windows, memory freeze, event counters.
module hazard_flush_unit #(
  parameter int REG_W       = 5,
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_readdmem,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             br_taken,
  input  logic             mem_stall,
  input  logic             cnt_clr,
  output logic             flush,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_events,
  output logic [CNT_W-1:0] flush_events
);

  localparam int MAXC =
    (FLUSH_DEPTH > LOAD_LAT) ? FLUSH_DEPTH : LOAD_LAT;
  localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0] FD_M1 = CW'(FLUSH_DEPTH - 1);
  localparam logic [CW-1:0] LL_M1 = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] sev_q, sev_d;
  logic [CNT_W-1:0] fev_q, fev_d;

  logic hz;
  logic rs_hit, rt_hit;
  logic flush_c, stall_pc_c, stall_ifid_c, redirect_c;
  logic sev_inc, fev_inc;

  // Load-use hazard: EX load targets a register ID actually reads.
  always_comb begin
    rs_hit = id_use_rs & (id_rs == ex_rd);
    rt_hit = id_use_rt & (id_rt == ex_rd);
    hz     = ex_readdmem & (ex_rd != '0) & (rs_hit | rt_hit);
  end

  // Next state, window counter and combinational pipeline controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_c      = 1'b0;
    stall_pc_c   = 1'b0;
    stall_ifid_c = 1'b0;
    redirect_c   = 1'b0;
    sev_inc      = 1'b0;
    fev_inc      = 1'b0;
    if (mem_stall) begin
      stall_pc_c   = 1'b1;
      stall_ifid_c = 1'b1;
    end else begin
      unique case (state_q)
        RUN, LDSTALL: begin
          if (br_taken) begin
            flush_c    = 1'b1;
            redirect_c = 1'b1;
            fev_inc    = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_d = FLUSH;
              cnt_d   = FD_M1;
            end else begin
              state_d = RUN;
            end
          end else if (state_q == LDSTALL) begin
            flush_c      = 1'b1;
            stall_pc_c   = 1'b1;
            stall_ifid_c = 1'b1;
            cnt_d        = cnt_q - ONE;
            if (cnt_q == ONE) begin
              state_d = RUN;
            end
          end else if (hz) begin
            flush_c      = 1'b1;
            stall_pc_c   = 1'b1;
            stall_ifid_c = 1'b1;
            sev_inc      = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LDSTALL;
              cnt_d   = LL_M1;
            end
          end
        end
        FLUSH: begin
          flush_c = 1'b1;
          if (br_taken) begin
            redirect_c = 1'b1;
            fev_inc    = 1'b1;
            cnt_d      = FD_M1;
          end else begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
              state_d = RUN;
            end
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating event counters; clear wins over increment.
  always_comb begin
    sev_d = sev_q;
    fev_d = fev_q;
    if (cnt_clr) begin
      sev_d = '0;
      fev_d = '0;
    end else begin
      if (sev_inc && (sev_q != '1)) begin
        sev_d = sev_q + CNT_W'(1);
      end
      if (fev_inc && (fev_q != '1)) begin
        fev_d = fev_q + CNT_W'(1);
      end
    end
  end

  // State, window counter and event counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      sev_q   <= '0;
      fev_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sev_q   <= sev_d;
      fev_q   <= fev_d;
    end
  end

  // Controls are gated by reset so the pipeline is released at once.
  always_comb begin
    flush        = rst_n & flush_c;
    stall_pc     = rst_n & stall_pc_c;
    stall_ifid   = rst_n & stall_ifid_c;
    redirect     = rst_n & redirect_c;
    stall_events = sev_q;
    flush_events = fev_q;
  end

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Scoreboard bench for hazard_flush_unit.
// Two instances: LOAD_LAT=1 and LOAD_LAT=3, shared inputs.
module tb_hazard_flush_unit;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_readdmem;
  logic br_taken, mem_stall, cnt_clr;

  logic f1, sp1, si1, r1;
  logic f2, sp2, si2, r2;
  logic [CW-1:0] sev1, fev1, sev2, fev2;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] exp_sev;
  logic [CW-1:0] exp_fev;

  typedef struct {
    string        tag;
    logic [3:0]   o1;
    logic [3:0]   o2;
    logic         use2;
    logic [CW-1:0] sev;
    logic [CW-1:0] fev;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_flush_unit #(
    .REG_W(5), .FLUSH_DEPTH(2), .LOAD_LAT(1), .CNT_W(CW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_readdmem(ex_readdmem), .ex_rd(ex_rd),
    .br_taken(br_taken), .mem_stall(mem_stall),
    .cnt_clr(cnt_clr),
    .flush(f1), .stall_pc(sp1), .stall_ifid(si1),
    .redirect(r1),
    .stall_events(sev1), .flush_events(fev1)
  );

  hazard_flush_unit #(
    .REG_W(5), .FLUSH_DEPTH(2), .LOAD_LAT(3), .CNT_W(CW)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_readdmem(ex_readdmem), .ex_rd(ex_rd),
    .br_taken(br_taken), .mem_stall(mem_stall),
    .cnt_clr(cnt_clr),
    .flush(f2), .stall_pc(sp2), .stall_ifid(si2),
    .redirect(r2),
    .stall_events(sev2), .flush_events(fev2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "/o1"}, 32'({f1, sp1, si1, r1}), 32'(e.o1));
      chk({e.tag, "/sev"}, 32'(sev1), 32'(e.sev));
      chk({e.tag, "/fev"}, 32'(fev1), 32'(e.fev));
      if (e.use2) begin
        chk({e.tag, "/o2"}, 32'({f2, sp2, si2, r2}), 32'(e.o2));
      end
    end
  end

  task automatic step(
    input string      tag,
    input logic [3:0] o1,
    input logic [3:0] o2,
    input logic       use2
  );
    exp_t e;
    e.tag  = tag;
    e.o1   = o1;
    e.o2   = o2;
    e.use2 = use2;
    e.sev  = exp_sev;
    e.fev  = exp_fev;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs       = '0;
    id_rt       = '0;
    ex_rd       = '0;
    id_use_rs   = 1'b0;
    id_use_rt   = 1'b0;
    ex_readdmem = 1'b0;
    br_taken    = 1'b0;
    mem_stall   = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  task automatic set_hz(input logic [4:0] r);
    ex_readdmem = 1'b1;
    ex_rd       = r;
    id_rs       = r;
    id_use_rs   = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    exp_sev = '0;
    exp_fev = '0;
    clr_in();
    @(posedge clk);
    #1;
    // reset forces outputs low whatever the inputs
    set_hz(5'd5);
    br_taken  = 1'b1;
    mem_stall = 1'b1;
    step("rst_ms", 4'b0000, 4'b0000, 1);
    mem_stall = 1'b0;
    step("rst_br", 4'b0000, 4'b0000, 1);
    clr_in();
    rst_n = 1'b1;
    step("idle", 4'b0000, 4'b0000, 1);

    // load-use on rs
    set_hz(5'd5);
    step("ld0", 4'b1110, 4'b1110, 1);
    clr_in();
    exp_sev = 1;
    step("ld1", 4'b0000, 4'b1110, 1);
    step("ld2", 4'b0000, 4'b1110, 1);
    step("ld3", 4'b0000, 4'b0000, 1);

    // r0 never hazards; unused rt never hazards
    ex_readdmem = 1'b1;
    id_use_rs   = 1'b1;
    id_use_rt   = 1'b1;
    step("r0", 4'b0000, 4'b0000, 1);
    ex_rd     = 5'd7;
    id_rt     = 5'd7;
    id_rs     = 5'd3;
    id_use_rt = 1'b0;
    step("no_use", 4'b0000, 4'b0000, 1);
    id_use_rt = 1'b1;
    step("rt0", 4'b1110, 4'b1110, 1);
    clr_in();
    exp_sev = 2;
    step("rt1", 4'b0000, 4'b1110, 1);
    step("rt2", 4'b0000, 4'b1110, 1);
    step("rt3", 4'b0000, 4'b0000, 1);

    // taken branch flush window
    br_taken = 1'b1;
    step("br0", 4'b1001, 4'b1001, 1);
    br_taken = 1'b0;
    exp_fev = 1;
    step("br1", 4'b1000, 4'b1000, 1);
    step("br2", 4'b0000, 4'b0000, 1);

    // branch beats hazard
    br_taken = 1'b1;
    set_hz(5'd9);
    step("bh0", 4'b1001, 4'b1001, 1);
    clr_in();
    exp_fev = 2;
    step("bh1", 4'b1000, 4'b1000, 1);
    step("bh2", 4'b0000, 4'b0000, 1);

    // memory stall inside flush window
    br_taken = 1'b1;
    step("mf0", 4'b1001, 4'b1001, 1);
    br_taken  = 1'b0;
    mem_stall = 1'b1;
    exp_fev = 3;
    for (int i = 0; i < 3; i++) begin
      step("mf_stl", 4'b0110, 4'b0110, 1);
    end
    mem_stall = 1'b0;
    step("mf_rel", 4'b1000, 4'b1000, 1);
    step("mf_end", 4'b0000, 4'b0000, 1);

    // branch in flush restarts window
    br_taken = 1'b1;
    step("rs0", 4'b1001, 4'b1001, 1);
    exp_fev = 4;
    step("rs1", 4'b1001, 4'b1001, 1);
    br_taken = 1'b0;
    exp_fev = 5;
    step("rs2", 4'b1000, 4'b1000, 1);
    step("rs3", 4'b0000, 4'b0000, 1);

    // hazard ignored while flushing
    br_taken = 1'b1;
    step("fh0", 4'b1001, 4'b1001, 1);
    br_taken = 1'b0;
    set_hz(5'd4);
    exp_fev = 6;
    step("fh1", 4'b1000, 4'b1000, 1);
    clr_in();
    step("fh2", 4'b0000, 4'b0000, 1);

    // branch aborts load stall
    set_hz(5'd6);
    step("ab0", 4'b1110, 4'b1110, 1);
    clr_in();
    br_taken = 1'b1;
    exp_sev = 3;
    step("ab1", 4'b1001, 4'b1001, 1);
    br_taken = 1'b0;
    exp_fev = 7;
    step("ab2", 4'b1000, 4'b1000, 1);
    step("ab3", 4'b0000, 4'b0000, 1);

    // memory stall dominates in RUN, no counting
    mem_stall = 1'b1;
    br_taken  = 1'b1;
    set_hz(5'd2);
    step("mr0", 4'b0110, 4'b0110, 1);
    clr_in();
    step("mr1", 4'b0000, 4'b0000, 1);

    // clear beats same-cycle increment
    cnt_clr = 1'b1;
    set_hz(5'd8);
    step("ch0", 4'b1110, 4'b1110, 1);
    clr_in();
    exp_sev = 0;
    exp_fev = 0;
    step("ch1", 4'b0000, 4'b1110, 1);
    step("ch2", 4'b0000, 4'b1110, 1);
    step("ch3", 4'b0000, 4'b0000, 1);

    // saturation after 2^CW+3 hazards
    set_hz(5'd11);
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      step("sat", 4'b1110, 4'b0000, 0);
      if (exp_sev != {CW{1'b1}}) exp_sev = exp_sev + 1'b1;
    end
    clr_in();
    step("sat_end", 4'b0000, 4'b0000, 0);

    // clear honoured during memory stall
    mem_stall = 1'b1;
    cnt_clr   = 1'b1;
    step("cm0", 4'b0110, 4'b0110, 1);
    clr_in();
    exp_sev = 0;
    for (int i = 0; i < 3; i++) begin
      step("cm_idle", 4'b0000, 4'b0000, 0);
    end

    // reset during load stall releases at once
    set_hz(5'd13);
    step("rl0", 4'b1110, 4'b1110, 1);
    clr_in();
    rst_n = 1'b0;
    step("rl_rst", 4'b0000, 4'b0000, 1);
    rst_n = 1'b1;
    step("rl_rel", 4'b0000, 4'b0000, 1);
    step("rl_idle", 4'b0000, 4'b0000, 1);

    for (int i = 0; i < 4 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() > 0) begin
      chk("drain", 32'(sb.size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
